// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: session FSM states and the default MISR/LFSR polynomial constants.
package lbist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } lbist_state_t;

    // x^16 + x^5 + x^3 + x^2 + 1, shared with the pattern-generator LFSR
    localparam int          LBIST_SIG_W = 16;
    localparam logic [15:0] LBIST_POLY  = 16'h002D;
    localparam logic [15:0] LBIST_SEED  = 16'h0000;

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register: Galois-style shift with polynomial feedback,
// XORing one zero-extended CUT response into the low bits per enabled cycle.
module lbist_misr
    import lbist_pkg::*;
#(
    parameter int               SIG_W = LBIST_SIG_W,
    parameter int               OUT_W = 2,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(LBIST_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(LBIST_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [OUT_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] feedback;
    logic [SIG_W-1:0] din_ext;
    logic [SIG_W-1:0] sig_next;

    always_comb begin
        feedback = sig[SIG_W-1] ? POLY : '0;
        din_ext  = SIG_W'(din);
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ feedback ^ din_ext;
    end

    // load wins over en so a session restart never mixes in a stray response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/lbist_misr_ctrl.sv
// Response-side LBIST controller: sequences a fixed-length session, paces the pattern
// generator, compacts CUT responses in the MISR and compares against a golden signature.
module lbist_misr_ctrl
    import lbist_pkg::*;
#(
    parameter int               OUT_W   = 2,
    parameter int               SIG_W   = LBIST_SIG_W,
    parameter int               NUM_PAT = 32,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(LBIST_POLY),
    parameter logic [SIG_W-1:0] SEED    = SIG_W'(LBIST_SEED),
    parameter logic [SIG_W-1:0] GOLDEN  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [OUT_W-1:0] resp,
    output logic             pat_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int               CNT_W    = $clog2(NUM_PAT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PAT - 1);

    lbist_state_t     state;
    lbist_state_t     state_next;
    logic [CNT_W-1:0] count;
    logic             misr_load;
    logic             misr_en;

    lbist_misr #(
        .SIG_W (SIG_W),
        .OUT_W (OUT_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (misr_load),
        .en   (misr_en),
        .din  (resp),
        .sig  (signature)
    );

    always_comb begin
        state_next = state;
        misr_load  = 1'b0;
        misr_en    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    misr_load  = 1'b1;
                end
            end
            RUN: begin
                if (resp_valid) begin
                    misr_en = 1'b1;
                    if (count == LAST_CNT) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The final response is counted on the same edge that leaves RUN, so count never exceeds NUM_PAT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (misr_load) begin
            count <= '0;
        end else if (misr_en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Status flags are decoded from the next state so every output comes straight off a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
        end else begin
            pat_en <= (state_next == RUN);
            busy   <= (state_next == RUN) || (state_next == CHECK);
            done   <= (state_next == DONE);
            if (misr_load) begin
                pass <= 1'b0;
            end else if (state == CHECK) begin
                pass <= (signature == GOLDEN);
            end
        end
    end

endmodule

// File: tb/tb_lbist_misr_ctrl.sv
// Directed/randomized bench for lbist_misr_ctrl: five parameterised instances cover the
// single-pattern, feedback, cancellation, stall, abort and restart scenarios.
module tb_lbist_misr_ctrl;

    // Polynomial model: multiply by x modulo g(x) = x^16 + x^5 + x^3 + x^2 + 1, then add the response
    function automatic logic [15:0] model_step(input logic [15:0] s, input logic [1:0] r);
        logic [16:0] prod;
        prod = {s, 1'b0};
        if (prod[16]) prod = prod ^ 17'h1002D;
        return prod[15:0] ^ {14'b0, r};
    endfunction

    function automatic logic [1:0] gold_pat(input int k);
        return 2'((k * 7 + 1) % 4);
    endfunction

    function automatic logic [15:0] gold_sig();
        logic [15:0] s;
        s = 16'h1234;
        for (int k = 0; k < 32; k++) s = model_step(s, gold_pat(k));
        return s;
    endfunction

    localparam logic [15:0] GOLDEN0 = gold_sig();

    logic        clk;
    logic        rst;
    logic        start      [5];
    logic        resp_valid [5];
    logic [1:0]  resp       [5];
    logic        pat_en     [5];
    logic        busy       [5];
    logic        done       [5];
    logic        pass       [5];
    logic [15:0] sig        [5];

    int vectors;
    int miscompares;

    lbist_misr_ctrl #(.NUM_PAT(32), .SEED(16'h1234), .GOLDEN(GOLDEN0)) u_main (
        .clk(clk), .rst(rst), .start(start[0]), .resp_valid(resp_valid[0]), .resp(resp[0]),
        .pat_en(pat_en[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .signature(sig[0]));

    lbist_misr_ctrl #(.NUM_PAT(1), .SEED(16'h0000), .GOLDEN(16'h0003)) u_one (
        .clk(clk), .rst(rst), .start(start[1]), .resp_valid(resp_valid[1]), .resp(resp[1]),
        .pat_en(pat_en[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .signature(sig[1]));

    lbist_misr_ctrl #(.NUM_PAT(1), .SEED(16'h8000), .GOLDEN(16'h0000)) u_fb (
        .clk(clk), .rst(rst), .start(start[2]), .resp_valid(resp_valid[2]), .resp(resp[2]),
        .pat_en(pat_en[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .signature(sig[2]));

    lbist_misr_ctrl #(.NUM_PAT(2), .SEED(16'h0000), .GOLDEN(16'h0001)) u_can (
        .clk(clk), .rst(rst), .start(start[3]), .resp_valid(resp_valid[3]), .resp(resp[3]),
        .pat_en(pat_en[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]), .signature(sig[3]));

    lbist_misr_ctrl #(.NUM_PAT(4), .SEED(16'hACE1), .GOLDEN(16'h0000)) u_stall (
        .clk(clk), .rst(rst), .start(start[4]), .resp_valid(resp_valid[4]), .resp(resp[4]),
        .pat_en(pat_en[4]), .busy(busy[4]), .done(done[4]), .pass(pass[4]), .signature(sig[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Runs one session on instance idx; returns the model signature for the responses applied
    task automatic applyStimulus(input int idx, input logic [15:0] seed, input logic [1:0] pats[$],
                                 input int stall_at, input int stall_len, input int restart_at,
                                 output logic [15:0] exp_sig);
        int cycles;
        int exp_lat;
        exp_sig = seed;
        exp_lat = pats.size() + 2 + ((stall_at < pats.size()) ? stall_len : 0);
        @(negedge clk);
        start[idx] = 1'b1;
        @(negedge clk);
        start[idx] = 1'b0;
        cycles = 1;
        checkOutput("pass_cleared_on_start", 32'(pass[idx]), 32'd0);
        checkOutput("busy_in_run", 32'(busy[idx]), 32'd1);
        for (int k = 0; k < pats.size(); k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    resp_valid[idx] = 1'b0;
                    resp[idx] = 2'($urandom);
                    @(negedge clk);
                    cycles++;
                    checkOutput("pat_en_during_stall", 32'(pat_en[idx]), 32'd1);
                end
            end
            checkOutput("pat_en_in_run", 32'(pat_en[idx]), 32'd1);
            resp_valid[idx] = 1'b1;
            resp[idx] = pats[k];
            start[idx] = (k == restart_at);
            exp_sig = model_step(exp_sig, pats[k]);
            @(negedge clk);
            cycles++;
        end
        resp_valid[idx] = 1'b0;
        start[idx] = 1'b0;
        checkOutput("pat_en_falls", 32'(pat_en[idx]), 32'd0);
        for (int w = 0; w < 8 && !done[idx]; w++) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("done_reached", 32'(done[idx]), 32'd1);
        checkOutput("session_latency", 32'(cycles), 32'(exp_lat));
    endtask

    initial begin
        logic [1:0]  q[$];
        logic [15:0] exp_sig;
        logic [15:0] unstalled_sig;
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start[i] = 1'b0;
            resp_valid[i] = 1'b0;
            resp[i] = 2'b00;
        end
        repeat (3) @(negedge clk);

        checkOutput("reset_sig_main", 32'(sig[0]), 32'h1234);
        checkOutput("reset_sig_fb", 32'(sig[2]), 32'h8000);
        checkOutput("reset_sig_stall", 32'(sig[4]), 32'hACE1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("reset_pat_en", 32'(pat_en[i]), 32'd0);
            checkOutput("reset_busy", 32'(busy[i]), 32'd0);
            checkOutput("reset_done", 32'(done[i]), 32'd0);
            checkOutput("reset_pass", 32'(pass[i]), 32'd0);
        end
        rst = 1'b0;

        $display("[TB] single pattern");
        q = {2'b11};
        applyStimulus(1, 16'h0000, q, 99, 0, 99, exp_sig);
        checkOutput("single_sig", 32'(sig[1]), 32'h0003);
        checkOutput("single_pass", 32'(pass[1]), 32'd1);

        $display("[TB] feedback path");
        q = {2'b00};
        applyStimulus(2, 16'h8000, q, 99, 0, 99, exp_sig);
        checkOutput("feedback_sig", 32'(sig[2]), 32'h002D);
        checkOutput("feedback_pass", 32'(pass[2]), 32'd0);

        $display("[TB] cancellation");
        q = {2'b01, 2'b10};
        applyStimulus(3, 16'h0000, q, 99, 0, 99, exp_sig);
        checkOutput("cancel_sig", 32'(sig[3]), 32'h0000);
        checkOutput("cancel_pass", 32'(pass[3]), 32'd0);

        $display("[TB] stall");
        for (int r = 0; r < 3; r++) begin
            q = {};
            for (int k = 0; k < 4; k++) q.push_back(2'($urandom));
            applyStimulus(4, 16'hACE1, q, 99, 0, 99, exp_sig);
            unstalled_sig = exp_sig;
            checkOutput("unstalled_sig", 32'(sig[4]), 32'(exp_sig));
            applyStimulus(4, 16'hACE1, q, 2, 3, 99, exp_sig);
            checkOutput("stalled_sig", 32'(sig[4]), 32'(unstalled_sig));
            checkOutput("stalled_pass", 32'(pass[4]), 32'(exp_sig == 16'h0000));
        end

        $display("[TB] reset mid-run");
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            resp_valid[0] = 1'b1;
            resp[0] = 2'($urandom);
            @(negedge clk);
        end
        resp_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("abort_sig", 32'(sig[0]), 32'h1234);
        checkOutput("abort_busy", 32'(busy[0]), 32'd0);
        checkOutput("abort_done", 32'(done[0]), 32'd0);
        checkOutput("abort_pass", 32'(pass[0]), 32'd0);
        checkOutput("abort_pat_en", 32'(pat_en[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] golden session with ignored start");
        q = {};
        for (int k = 0; k < 32; k++) q.push_back(gold_pat(k));
        applyStimulus(0, 16'h1234, q, 99, 0, 10, exp_sig);
        checkOutput("golden_sig", 32'(sig[0]), 32'(exp_sig));
        checkOutput("golden_pass", 32'(pass[0]), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("done_hold", 32'(done[0]), 32'd1);
        checkOutput("sig_hold", 32'(sig[0]), 32'(exp_sig));

        $display("[TB] restart from done with random responses");
        q = {};
        for (int k = 0; k < 32; k++) q.push_back(2'($urandom));
        applyStimulus(0, 16'h1234, q, 7, 2, 99, exp_sig);
        checkOutput("random_sig", 32'(sig[0]), 32'(exp_sig));
        checkOutput("random_pass", 32'(pass[0]), 32'(exp_sig == GOLDEN0));

        q = {};
        for (int k = 0; k < 32; k++) q.push_back(gold_pat(k));
        applyStimulus(0, 16'h1234, q, 99, 0, 99, exp_sig);
        checkOutput("regolden_sig", 32'(sig[0]), 32'(exp_sig));
        checkOutput("regolden_pass", 32'(pass[0]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
